// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator and its clock generator.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_CLK_DIV = 4;

  // MISO capture point selection
  localparam int unsigned RX_ON_RISE  = 0;
  localparam int unsigned RX_LATE_CAP = 1;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter and SCLK level register; emits strobes for the SPI FSM.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic tog_i,
  output logic sclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o,
  output logic pre_rise_stb_c_o,
  output logic half_done_c_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, fall_q;
  logic          half_done_c, pre_rise_c, pre_fall_c;

  assign half_done_c = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign pre_rise_c  = half_done_c && tog_i && !lvl_q;
  assign pre_fall_c  = half_done_c && tog_i && lvl_q;

  // Counter and level fall back to zero whenever the FSM is idle
  always_comb begin
    cnt_d = '0;
    lvl_d = 1'b0;
    if (en_i) begin
      cnt_d = half_done_c ? '0 : cnt_q + CW'(1);
      lvl_d = (half_done_c && tog_i) ? ~lvl_q : lvl_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= pre_rise_c;
      fall_q <= pre_fall_c;
    end
  end

  // rise/fall strobes mark the first cycle the new SCLK level is visible
  assign sclk_o           = lvl_q;
  assign rise_stb_o       = rise_q;
  assign fall_stb_o       = fall_q;
  assign pre_rise_stb_c_o = pre_rise_c;
  assign half_done_c_o    = half_done_c;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one DATA_W-bit word per start/busy/done handshake.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned RX_LATE = RX_LATE_CAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned HW = $clog2(2 * DATA_W);

  state_e            state_q, state_d;
  logic              cs_q, cs_d, busy_q, busy_d, done_q, done_d, mosi_q, mosi_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d, rx_shift_c;
  logic [HW-1:0]     half_q, half_d;
  logic              rise_stb, fall_stb, pre_rise_c, half_done_c, capture_c;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk              (clk),
    .rst              (rst),
    .en_i             (state_q != IDLE),
    .tog_i            (state_q == SETUP || state_q == SHIFT),
    .sclk_o           (sclk),
    .rise_stb_o       (rise_stb),
    .fall_stb_o       (fall_stb),
    .pre_rise_stb_c_o (pre_rise_c),
    .half_done_c_o    (half_done_c)
  );

  // Late capture skips rise 1 and takes the last sample at the end of HOLD
  always_comb begin
    if (RX_LATE == RX_ON_RISE) begin
      capture_c = rise_stb;
    end else begin
      capture_c = (pre_rise_c && state_q == SHIFT) || (half_done_c && state_q == HOLD);
    end
    rx_shift_c = capture_c ? {rx_q[DATA_W-2:0], miso} : rx_q;
  end

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    rx_d      = rx_shift_c;
    rx_data_d = rx_data_q;
    half_d    = half_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          tx_d    = tx_data;
          mosi_d  = tx_data[DATA_W-1];
          rx_d    = '0;
          half_d  = '0;
        end
      end
      SETUP: begin
        if (half_done_c) state_d = SHIFT;
      end
      SHIFT: begin
        // mosi advances one cycle after SCLK falls so it never moves while SCLK is high
        if (fall_stb) begin
          tx_d   = tx_q << 1;
          mosi_d = tx_q[DATA_W-2];
        end
        if (half_done_c) begin
          if (half_q == HW'(2 * DATA_W - 2)) begin
            state_d = HOLD;
            half_d  = '0;
          end else begin
            half_d = half_q + HW'(1);
          end
        end
      end
      HOLD: begin
        if (half_done_c) begin
          state_d   = GAP;
          cs_d      = 1'b1;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_shift_c;
        end
      end
      GAP: begin
        if (half_done_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mosi_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      half_q    <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mosi_q    <= mosi_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      half_q    <= half_d;
    end
  end

  assign cs      = cs_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign mosi    = mosi_q;
  assign rx_data = rx_data_q;

endmodule
